// File: rtl/ddr4_tg_arb_pkg.sv
// Shared types and constants for the DDR4 traffic-generator multi-port arbiter.
package ddr4_tg_arb_pkg;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_LFSR  = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } entry_state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    // Taps 32,22,2,1 expressed as zero-based bit positions 31,21,1,0.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int WAIT_CNT_W = 8;
    localparam int STAT_CNT_W = 32;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ddr4_tg_arb_pick.sv
// Rotating-priority picker: starved requesters win by lowest index, otherwise the
// search starts at start_i and wraps from N-1 to 0. Grant is one-hot or zero.
module ddr4_tg_arb_pick
    import ddr4_tg_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    input  logic [N-1:0]         starved_i,
    output logic [N-1:0]         grant_o
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  hot;
    logic          found;
    logic [IW-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        hot     = req_i & starved_i;
        if (|hot) begin
            for (int i = 0; i < N; i++) begin
                if (!found && hot[i]) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = IW'((int'(start_i) + k) % N);
                if (!found && req_i[idx]) begin
                    grant_o[idx] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr4_tg_mport_arbiter.sv
// Multi-port TG arbiter feeding one app command/write-data port through a one-entry
// output register. Optional per-port grant statistics under macro TG_ARB_STATS_EN.
module ddr4_tg_mport_arbiter
    import ddr4_tg_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int APP_DATA_WIDTH = 32,
    parameter int APP_ADDR_WIDTH = 32,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int DM_WIDTH       = 8,
    parameter int MAX_WAIT       = 16,
    parameter int TCQ            = 100
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           init_calib_complete_r,
    input  logic [1:0]                                     arb_mode,
    input  logic [NUM_PORTS-1:0]                           req_en,
    input  logic [NUM_PORTS*APP_CMD_WIDTH-1:0]             req_cmd,
    input  logic [NUM_PORTS*APP_ADDR_WIDTH-1:0]            req_addr,
    input  logic [NUM_PORTS*APP_DATA_WIDTH-1:0]            req_wdf_data,
    input  logic [NUM_PORTS*(APP_DATA_WIDTH/DM_WIDTH)-1:0] req_wdf_mask,
    output logic [NUM_PORTS-1:0]                           req_rdy,
    input  logic                                           app_rdy,
    input  logic                                           app_wdf_rdy,
    output logic                                           app_en,
    output logic [APP_CMD_WIDTH-1:0]                       app_cmd,
    output logic [APP_ADDR_WIDTH-1:0]                      app_addr,
    output logic [APP_DATA_WIDTH-1:0]                      app_wdf_data,
    output logic [APP_DATA_WIDTH/DM_WIDTH-1:0]             app_wdf_mask,
    output logic                                           app_wdf_wren,
    output logic                                           app_wdf_end,
    output logic [NUM_PORTS-1:0]                           starve,
    output logic [NUM_PORTS*STAT_CNT_W-1:0]                stat_grant_cnt
);

    localparam int                    MASK_W   = APP_DATA_WIDTH / DM_WIDTH;
    localparam int                    IDX_W    = $clog2(NUM_PORTS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_WAIT);

    if (NUM_PORTS < 2 || NUM_PORTS > 8 || MAX_WAIT < 1 || MAX_WAIT > 255 || TCQ < 0) begin : g_param_check
        $error("ddr4_tg_mport_arbiter: parameter out of legal range");
    end

    entry_state_e          state_q, state_d;
    logic                  armed_q;
    logic [APP_CMD_WIDTH-1:0]  cmd_q, sel_cmd;
    logic [APP_ADDR_WIDTH-1:0] addr_q, sel_addr;
    logic [APP_DATA_WIDTH-1:0] data_q, sel_data;
    logic [MASK_W-1:0]         mask_q, sel_mask;
    logic                      wr_q;
    logic [IDX_W-1:0]          rr_q, rr_d, start_idx;
    logic [LFSR_W-1:0]         lfsr_q, lfsr_d;
    logic [WAIT_CNT_W-1:0]     wait_q [NUM_PORTS];
    logic [WAIT_CNT_W-1:0]     wait_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]      starved, pick_grant, grant, xfer;
    logic                      drain, can_grant, load;

    assign drain     = (state_q == ST_FULL) && app_rdy && (!wr_q || app_wdf_rdy);
    // armed_q delays the first grant until rst_n has been seen high on a clock edge.
    assign can_grant = armed_q && init_calib_complete_r && ((state_q == ST_EMPTY) || drain);

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) starved[i] = (wait_q[i] == WAIT_MAX);
    end

    always_comb begin
        start_idx = '0;
        case (arb_mode_e'(arb_mode))
            ARB_FIXED: start_idx = '0;
            ARB_LFSR:  start_idx = IDX_W'(lfsr_q % LFSR_W'(NUM_PORTS));
            default:   start_idx = (rr_q == IDX_W'(NUM_PORTS - 1)) ? '0 : rr_q + IDX_W'(1);
        endcase
    end

    ddr4_tg_arb_pick #(
        .N (NUM_PORTS)
    ) u_pick (
        .req_i     (req_en),
        .start_i   (start_idx),
        .starved_i (starved),
        .grant_o   (pick_grant)
    );

    assign grant   = can_grant ? pick_grant : '0;
    assign req_rdy = grant;
    assign xfer    = req_en & grant;
    assign load    = |xfer;

    always_comb begin
        sel_cmd  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_mask = '0;
        rr_d     = rr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (xfer[i]) begin
                sel_cmd  = req_cmd[i*APP_CMD_WIDTH +: APP_CMD_WIDTH];
                sel_addr = req_addr[i*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
                sel_data = req_wdf_data[i*APP_DATA_WIDTH +: APP_DATA_WIDTH];
                sel_mask = req_wdf_mask[i*MASK_W +: MASK_W];
                rr_d     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_FULL;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
        lfsr_d = init_calib_complete_r ? lfsr_next(lfsr_q) : lfsr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_en[i] || xfer[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WAIT_MAX) begin
                wait_d[i] = wait_q[i] + WAIT_CNT_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            state_q <= ST_EMPTY;
            rr_q    <= IDX_W'(NUM_PORTS - 1);
            lfsr_q  <= LFSR_SEED;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            // NOTE: the wait counters are state, not storage, so each entry is reset like any other flop.
            for (int i = 0; i < NUM_PORTS; i++) wait_q[i] <= '0;
        end else begin
            armed_q <= 1'b1;
            state_q <= state_d;
            rr_q    <= rr_d;
            lfsr_q  <= lfsr_d;
            for (int i = 0; i < NUM_PORTS; i++) wait_q[i] <= wait_d[i];
            if (load) begin
                cmd_q  <= sel_cmd;
                addr_q <= sel_addr;
                data_q <= sel_data;
                mask_q <= sel_mask;
                wr_q   <= (sel_cmd == APP_CMD_WIDTH'(CMD_WR));
            end
        end
    end

    assign app_en       = (state_q == ST_FULL);
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;
    assign app_wdf_wren = app_en && wr_q;
    assign app_wdf_end  = app_en && wr_q;
    assign starve       = starved;

`ifdef TG_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] stat_q [NUM_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (xfer[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + STAT_CNT_W'(1);
            end
        end
    end

    always_comb begin
        stat_grant_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) stat_grant_cnt[i*STAT_CNT_W +: STAT_CNT_W] = stat_q[i];
    end
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

// File: doc/ddr4_tg_mport_arbiter.md
DDR4_TG_MPORT_ARBITER -- requirements
Module: ddr4_tg_mport_arbiter

Interface
REQ-001 SHALL take parameter NUM_PORTS, default 4: number of TG request ports, legal range 2..8.
REQ-002 SHALL take parameter APP_DATA_WIDTH, default 32: app data width.
REQ-003 SHALL take parameter APP_ADDR_WIDTH, default 32: app address width.
REQ-004 SHALL take parameter APP_CMD_WIDTH, default 3: app command width.
REQ-005 SHALL take parameter DM_WIDTH, default 8: data bits per mask bit.
REQ-006 SHALL take parameter MAX_WAIT, default 16: starvation threshold in cycles, legal range 1..255.
REQ-007 SHALL take parameter TCQ, default 100: clock-to-q delay in ps.
REQ-008 Port clk, input, 1 bit: UI clock; one clock, all state on rising edge.
REQ-009 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 Port init_calib_complete_r, input, 1 bit: calibration done.
REQ-011 Port arb_mode, input, 2 bits: 0 fixed priority, 1 round-robin, 2 LFSR-random, 3 reserved (treated as 1).
REQ-012 Port req_en, input, NUM_PORTS bits: per-port command valid.
REQ-013 Port req_cmd / req_addr, input, NUM_PORTS*APP_CMD_WIDTH / NUM_PORTS*APP_ADDR_WIDTH bits: packed per-port command and address; port i in slice i.
REQ-014 Port req_wdf_data / req_wdf_mask, input, NUM_PORTS*APP_DATA_WIDTH / NUM_PORTS*(APP_DATA_WIDTH/DM_WIDTH) bits: packed per-port write beat.
REQ-015 Port req_rdy, output, NUM_PORTS bits: per-port accept; at most one bit high per cycle.
REQ-016 Port app_rdy / app_wdf_rdy, input, 1 bit each: memory controller ready.
REQ-017 Ports app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, output, widths as the app interface: shared command and write-data port.
REQ-018 Port starve, output, NUM_PORTS bits: port wait counter at MAX_WAIT.
REQ-019 Port stat_grant_cnt, output, NUM_PORTS*32 bits: per-port grant counters.

Function
REQ-020 A command is a write when req_cmd equals WR (3'b000); every other encoding is non-write.
REQ-021 SHALL contain a one-entry output register with states EMPTY and FULL.
REQ-022 The register drains when app_en && app_rdy && (non-write || app_wdf_rdy).
REQ-023 SHALL grant only when init_calib_complete_r is high and the register is EMPTY or draining; the grant raises req_rdy[g] for the winning requester in that same cycle.
REQ-024 The transfer req_en[g] && req_rdy[g] loads the register; app_en is high the next cycle (latency 1); back-to-back grants sustain 1 command per cycle.
REQ-025 app_wdf_wren = app_wdf_end = app_en && write; write data and mask travel with the command.
REQ-026 Mode 0: lowest index wins.
REQ-027 Mode 1: search starts at last granted+1 and wraps from NUM_PORTS-1 to 0.
REQ-028 LFSR: 32-bit, seed 1, taps 32,22,2,1, advances every cycle while init_calib_complete_r is high.
REQ-029 Mode 2: search starts at lfsr mod NUM_PORTS and wraps as in mode 1.
REQ-030 Per-port 8-bit wait counter increments while req_en && !req_rdy, saturates at MAX_WAIT, and clears on that port's transfer or when req_en is low.
REQ-031 Any starved port overrides arb_mode; among starved ports the lowest index wins.
REQ-032 An arb_mode change affects only the next grant; a held entry is unaffected.
REQ-033 A FULL register SHALL hold all app_* outputs stable until it drains.
REQ-034 With no requester, req_rdy is all zero and the register goes EMPTY after a drain.

Reset
REQ-035 rst_n low SHALL drop any held entry and force app_en=0, app_wdf_wren=0, app_wdf_end=0, req_rdy=0, starve=0, app_cmd/addr/data/mask=0, wait counters=0, round-robin pointer=NUM_PORTS-1, LFSR=1, stat counters=0.
REQ-036 Reset deassertion SHALL be used synchronised; the first grant is possible on the cycle after rst_n is sampled high.

Configuration
REQ-037 Macro TG_ARB_STATS_EN defined: each stat_grant_cnt slice counts that port's transfers, saturating at 32'hFFFF_FFFF.
REQ-038 Macro TG_ARB_STATS_EN undefined: stat_grant_cnt tied to zero and no counter flops present.

Structure
REQ-039 Package ddr4_tg_arb_pkg SHALL hold the arb_mode enum, the WR/RD command encodings, the LFSR taps and seed, and the counter widths.
REQ-040 Sub-module ddr4_tg_arb_pick SHALL implement the rotating-priority picker (request vector, start index, starved vector in -> one-hot grant out).

Verification
REQ-041 Mode 0, req_en=4'b1010 held, app_rdy=1: grants port1 every cycle; after 16 cycles starve[3]=1 and port3 is granted next.
REQ-042 Mode 1, all four ports requesting: grant order 0,1,2,3,0 with app_en high every cycle.
REQ-043 Port2 write, addr 0x40, data 0xA5A5A5A5, app_wdf_rdy=0 for 3 cycles: app_en, app_wdf_wren and app_addr held 3 cycles; drains on cycle 4; req_rdy all zero meanwhile.
REQ-044 rst_n pulsed low while FULL: app_en=0 asynchronously; after release, first grant follows round-robin pointer reset (port0).
REQ-045 init_calib_complete_r=0 with all req_en=1: req_rdy=0 and LFSR frozen at 1 for 10 cycles.
REQ-046 TG_ARB_STATS_EN build, 100 port0 transfers: stat_grant_cnt slice 0 = 100, other slices 0.
